// File: rtl/rom_arbiter.sv
// Two-port read arbiter in front of a shared synchronous ROM.
// Port 0 has priority; port 1 gets a forced grant after MAX_WAIT denials.
module rom_arbiter #(
  parameter int WORD_SIZE = 20,
  parameter int ADDR_SIZE = 16,
  parameter int MAX_WAIT  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0_i,
  input  logic [ADDR_SIZE-1:0] addr0_i,
  output logic                 gnt0_o,
  output logic                 rvalid0_o,
  output logic [WORD_SIZE-1:0] rdata0_o,
  input  logic                 req1_i,
  input  logic [ADDR_SIZE-1:0] addr1_i,
  output logic                 gnt1_o,
  output logic                 rvalid1_o,
  output logic [WORD_SIZE-1:0] rdata1_o,
  output logic [ADDR_SIZE-1:0] rom_addr_o,
  input  logic [WORD_SIZE-1:0] rom_value_i
);

  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  logic [3:0]           wait_cnt;
  logic                 wait_full;
  logic                 pick0;
  logic                 pick1;
  logic [ADDR_SIZE-1:0] last_addr;
  logic                 tag_valid;
  logic                 tag_port;

  assign wait_full = (wait_cnt == WAIT_MAX);

  // Port 1 wins only when port 0 is idle or port 1 has starved long enough.
  always_comb begin
    pick1 = req1_i && (!req0_i || wait_full);
    pick0 = req0_i && !pick1;
  end

  assign gnt0_o = pick0 && !reset;
  assign gnt1_o = pick1 && !reset;

  always_comb begin
    rom_addr_o = last_addr;
    if (gnt0_o)
      rom_addr_o = addr0_i;
    else if (gnt1_o)
      rom_addr_o = addr1_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (!req1_i || gnt1_o) begin
      wait_cnt <= '0;
    end else if (!wait_full) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  // Holding the last granted address keeps the ROM output quiet when idle.
  always_ff @(posedge clk) begin
    if (reset)
      last_addr <= '0;
    else if (gnt0_o || gnt1_o)
      last_addr <= rom_addr_o;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tag_valid <= 1'b0;
      tag_port  <= 1'b0;
    end else begin
      tag_valid <= gnt0_o || gnt1_o;
      tag_port  <= gnt1_o;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid0_o <= 1'b0;
      rvalid1_o <= 1'b0;
      rdata0_o  <= '0;
      rdata1_o  <= '0;
    end else begin
      rvalid0_o <= tag_valid && !tag_port;
      rvalid1_o <= tag_valid && tag_port;
      if (tag_valid && !tag_port)
        rdata0_o <= rom_value_i;
      if (tag_valid && tag_port)
        rdata1_o <= rom_value_i;
    end
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// Scoreboard bench for rom_arbiter with a behavioural synchronous ROM.
// Expected grants come from an independent wait-counter model.
module tb_rom_arbiter;

  localparam int WS = 20;
  localparam int AS = 16;
  localparam int MW = 4;

  typedef struct {
    logic [WS-1:0] data;
    int            due;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req0 = 1'b0;
  logic          req1 = 1'b0;
  logic [AS-1:0] addr0 = '0;
  logic [AS-1:0] addr1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [WS-1:0] rdata0, rdata1, rom_value;
  logic [AS-1:0] rom_addr;

  int n_run = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_rsp1 = 0;
  bit mon_en = 1'b0;
  int m_wait = 0;
  logic [AS-1:0] m_last = '0;
  logic [WS-1:0] h0 = '0;
  logic [WS-1:0] h1 = '0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  rom_arbiter #(.WORD_SIZE(WS), .ADDR_SIZE(AS), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset),
    .req0_i(req0), .addr0_i(addr0), .gnt0_o(gnt0),
    .rvalid0_o(rvalid0), .rdata0_o(rdata0),
    .req1_i(req1), .addr1_i(addr1), .gnt1_o(gnt1),
    .rvalid1_o(rvalid1), .rdata1_o(rdata1),
    .rom_addr_o(rom_addr), .rom_value_i(rom_value)
  );

  function automatic logic [WS-1:0] rom_f(input logic [AS-1:0] a);
    if (a == 16'h0010) return 20'hABCDE;
    return {a[3:0], a} ^ 20'h5A5A5;
  endfunction

  always @(posedge clk) rom_value <= rom_f(rom_addr);

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  // Per-cycle monitor: responses, held data, grants and ROM address.
  always @(negedge clk) begin
    exp_t e;
    logic eg0, eg1;
    if (mon_en) begin
      if (rvalid0) begin
        if (q0.size() == 0) check("rvalid0_spurious", 1, 0);
        else begin
          e = q0.pop_front();
          check("rdata0", 32'(rdata0), 32'(e.data));
          check("lat0", cyc, e.due);
          h0 = e.data;
        end
      end else if (q0.size() != 0 && q0[0].due <= cyc)
        check("rvalid0_missing", 0, 1);
      if (rvalid1) begin
        n_rsp1++;
        if (q1.size() == 0) check("rvalid1_spurious", 1, 0);
        else begin
          e = q1.pop_front();
          check("rdata1", 32'(rdata1), 32'(e.data));
          check("lat1", cyc, e.due);
          h1 = e.data;
        end
      end else if (q1.size() != 0 && q1[0].due <= cyc)
        check("rvalid1_missing", 0, 1);
      check("hold0", 32'(rdata0), 32'(h0));
      check("hold1", 32'(rdata1), 32'(h1));

      eg1 = !reset && req1 && (!req0 || m_wait == MW);
      eg0 = !reset && req0 && !eg1;
      check("gnt0", 32'(gnt0), 32'(eg0));
      check("gnt1", 32'(gnt1), 32'(eg1));
      if (!reset)
        check("rom_addr", 32'(rom_addr),
              32'(eg0 ? addr0 : eg1 ? addr1 : m_last));
      if (eg0) begin
        q0.push_back('{rom_f(addr0), cyc + 2});
        m_last = addr0;
      end
      if (eg1) begin
        q1.push_back('{rom_f(addr1), cyc + 2});
        m_last = addr1;
      end

      if (reset || !req1 || eg1) m_wait = 0;
      else if (m_wait < MW) m_wait++;
      if (reset) begin
        q0.delete();
        q1.delete();
        h0 = '0;
        h1 = '0;
        m_last = '0;
      end
    end
    cyc++;
  end

  task automatic drive(input logic rst, input logic r0,
                       input logic [AS-1:0] a0, input logic r1,
                       input logic [AS-1:0] a1);
    @(posedge clk);
    #1;
    reset = rst;
    req0 = r0;
    addr0 = a0;
    req1 = r1;
    addr1 = a1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
  endtask

  initial begin
    int base;
    reset = 1'b1;
    req0 = 1'b1;
    req1 = 1'b1;
    addr0 = 16'h0007;
    addr1 = 16'h0009;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    drive(1'b1, 1'b1, 16'h0007, 1'b1, 16'h0009);
    @(negedge clk);
    check("rst_rvalid0", 32'(rvalid0), 0);
    check("rst_rvalid1", 32'(rvalid1), 0);
    check("rst_rdata0", 32'(rdata0), 0);
    check("rst_rdata1", 32'(rdata1), 0);

    // Single port-0 read right out of reset.
    drive(1'b0, 1'b1, 16'h0010, 1'b0, 16'h0);
    idle(4);

    // Both ports saturated: expect 0,0,0,0,1 repeating.
    base = n_rsp1;
    for (int i = 0; i < 20; i++)
      drive(1'b0, 1'b1, 16'(16'h0100 + i), 1'b1, 16'(16'h0200 + i));
    idle(4);
    @(negedge clk);
    #1;
    check("p1_responses", n_rsp1 - base, 4);

    // Port 1 alone, back-to-back.
    for (int i = 0; i < 6; i++)
      drive(1'b0, 1'b0, 16'h0, 1'b1, 16'(i));
    idle(4);

    // Grant 0x0123 then idle: address must stay parked.
    drive(1'b0, 1'b0, 16'h0, 1'b1, 16'h0123);
    idle(10);

    // Reset right after a grant discards the read.
    drive(1'b0, 1'b1, 16'h0044, 1'b0, 16'h0);
    drive(1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
    drive(1'b0, 1'b1, 16'h0055, 1'b1, 16'h0066);
    idle(4);
    @(negedge clk);
    #1;
    check("post_rst_rdata0", 32'(rdata0), 32'(rom_f(16'h0055)));

    for (int i = 0; i < 300; i++)
      drive(1'b0 || ($urandom_range(0, 40) == 0),
            1'($urandom_range(0, 2) != 0), 16'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), 16'($urandom_range(0, 255)));
    idle(5);
    @(negedge clk);
    #1;
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
